mem_port_arbiter: RTL and testbench

- Shares the single `memory` port (one `mem_control_t` in, one XLEN read-data out) among NUM_REQ requesters, e.g. hart fetch/load/store, a peripheral DMA and a debug port.
- Grants at most one request per cycle: round-robin, valid/ready handshake.
- Memory reads are synchronous, so read data is routed back to the granted requester one cycle after grant.
- Sits between the hart-side requesters and the `memory` instance.

---
 rtl/isa_types.sv | 38 +++
 rtl/mem_port_arbiter_rr_picker.sv | 31 +++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_types.sv
// isa_types: shared ISA and memory-port types for the hart.
// Also carries the arbiter state encoding and the memory read latency.
package isa_types;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    write_byte,
    write_half,
    write_word
  } mem_width_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            wenable;
    logic [XLEN-1:0] wdata;
    mem_width_t      wwidth;
  } mem_control_t;

  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arb_state_t;

  localparam int MEM_READ_LATENCY = 1;

  localparam mem_control_t MEM_IDLE = '{
    addr:    '0,
    wenable: 1'b0,
    wdata:   '0,
    wwidth:  write_byte
  };

  function automatic int wrap_inc(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rr_picker: rotate-priority encoder, first valid at or after ptr wins.
// Purely combinational so any arbiter can wrap its own pointer logic.
module rr_picker #(
  parameter int NUM_REQ   = 3,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [REQ_IDX_W-1:0] idx,
  output logic                 any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j -= NUM_REQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        idx      = REQ_IDX_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of the single memory port.
// Define MEM_ARB_LOCK_EN to let a requester hold the port across beats.
module mem_port_arbiter
  import isa_types::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic         [NUM_REQ-1:0] req_valid,
  input  mem_control_t [NUM_REQ-1:0] req_ctrl,
  input  logic         [NUM_REQ-1:0] req_lock,
  output logic         [NUM_REQ-1:0] req_ready,
  output logic         [NUM_REQ-1:0] rsp_valid,
  output logic         [XLEN-1:0]    rsp_rdata,
  output mem_control_t               mem_ctrl,
  input  logic         [XLEN-1:0]    mem_rdata
);

  logic [REQ_IDX_W-1:0] rr_ptr;
  logic [REQ_IDX_W-1:0] ptr_nxt;
  logic [REQ_IDX_W-1:0] win;
  logic [NUM_REQ-1:0]   pick_valid;
  logic [NUM_REQ-1:0]   pick_grant;
  logic                 pick_any;
  logic                 accept;

  logic [MEM_READ_LATENCY-1:0] pipe_v;
  logic [REQ_IDX_W-1:0]        pipe_idx [MEM_READ_LATENCY];

  function automatic logic [REQ_IDX_W-1:0] next_ptr(
    input logic [REQ_IDX_W-1:0] i
  );
    return REQ_IDX_W'(wrap_inc(int'(i), NUM_REQ));
  endfunction

  rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .REQ_IDX_W(REQ_IDX_W)
  ) u_pick (
    .valid(pick_valid),
    .ptr  (rr_ptr),
    .grant(pick_grant),
    .idx  (win),
    .any  (pick_any)
  );

  assign accept = pick_any && !reset;

`ifdef MEM_ARB_LOCK_EN
  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [REQ_IDX_W-1:0] lock_owner;
  logic [REQ_IDX_W-1:0] owner_nxt;
  logic [NUM_REQ-1:0]   owner_mask;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB_FREE;
      lock_owner <= '0;
    end else begin
      state      <= state_nxt;
      lock_owner <= owner_nxt;
    end
  end

  // Pointer is frozen while locked; unlock resumes after the owner.
  always_comb begin
    state_nxt = state;
    owner_nxt = lock_owner;
    ptr_nxt   = rr_ptr;
    unique case (state)
      ARB_FREE: begin
        if (accept) begin
          ptr_nxt = next_ptr(win);
          if (req_lock[win]) begin
            state_nxt = ARB_LOCKED;
            owner_nxt = win;
          end
        end
      end
      ARB_LOCKED: begin
        if (accept && !req_lock[win]) begin
          state_nxt = ARB_FREE;
          ptr_nxt   = next_ptr(win);
        end
      end
    endcase
  end

  assign owner_mask = NUM_REQ'(1) << lock_owner;
  assign pick_valid = (state == ARB_LOCKED)
                    ? (req_valid & owner_mask)
                    : req_valid;
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign pick_valid  = req_valid;

  always_comb begin
    ptr_nxt = rr_ptr;
    if (accept) ptr_nxt = next_ptr(win);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) rr_ptr <= '0;
    else       rr_ptr <= ptr_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_v <= '0;
      for (int i = 0; i < MEM_READ_LATENCY; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_v[0]   <= accept;
      pipe_idx[0] <= win;
      for (int i = 1; i < MEM_READ_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Response is masked during reset so an in-flight op is dropped.
  always_comb begin
    req_ready = reset ? '0 : pick_grant;
    mem_ctrl  = MEM_IDLE;
    if (accept) mem_ctrl = req_ctrl[win];
    rsp_valid = '0;
    if (pipe_v[MEM_READ_LATENCY-1] && !reset)
      rsp_valid[pipe_idx[MEM_READ_LATENCY-1]] = 1'b1;
    rsp_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario bench with a response scoreboard.
// Includes a synchronous memory model behind the arbiter.
module tb_mem_port_arbiter;
  import isa_types::*;

  localparam int N = 3;

  typedef struct {
    int          idx;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_lock;
  logic [N-1:0] req_ready;
  logic [N-1:0] rsp_valid;
  mem_control_t [N-1:0] req_ctrl;
  mem_control_t mem_ctrl;
  mem_control_t ctrl_q;
  logic [XLEN-1:0] rsp_rdata;
  logic [XLEN-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [31:0] wmem [int];

  always #5 clock = ~clock;

  mem_port_arbiter #(.NUM_REQ(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ctrl (req_ctrl),
    .req_lock (req_lock),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .mem_ctrl (mem_ctrl),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(int w);
    if (w == 4) return 32'hDEADBEEF;
    if (w == 'h304) return 32'hAABBCCDD;
    return 32'hA5000000 | w;
  endfunction

  function automatic mem_control_t rd(logic [31:0] a);
    return '{addr: a, wenable: 1'b0, wdata: '0, wwidth: write_byte};
  endfunction

  function automatic mem_control_t wr(logic [31:0] a, logic [31:0] d,
                                      mem_width_t wd);
    return '{addr: a, wenable: 1'b1, wdata: d, wwidth: wd};
  endfunction

  always @(negedge clock) ctrl_q = mem_ctrl;

  always @(posedge clock) begin
    logic [31:0] cur;
    int w;
    w = int'(ctrl_q.addr[13:2]);
    cur = wmem.exists(w) ? wmem[w] : init_word(w);
    mem_rdata <= cur;
    if (ctrl_q.wenable === 1'b1) begin
      case (ctrl_q.wwidth)
        write_byte: cur[{ctrl_q.addr[1:0], 3'b000} +: 8] = ctrl_q.wdata[7:0];
        write_half: cur[{ctrl_q.addr[1], 4'b0000} +: 16] = ctrl_q.wdata[15:0];
        default:    cur = ctrl_q.wdata;
      endcase
      wmem[w] = cur;
    end
  end

  // Scoreboard: expectations pushed at grant, checked one cycle later.
  always @(posedge clock) begin
    exp_t e;
    logic [N-1:0] oh;
    #3;
    if (reset === 1'b1) begin
      sb.delete();
      checks++;
      if (rsp_valid !== '0 || req_ready !== '0) begin
        errors++;
        $display("FAIL in_reset: rsp_valid=%b req_ready=%b want 000/000",
                 rsp_valid, req_ready);
      end
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        oh = N'(1) << e.idx;
        checks++;
        if (rsp_valid !== oh) begin
          errors++;
          $display("FAIL sb_rsp_valid: got %b want %b", rsp_valid, oh);
        end
        if (e.rd) begin
          checks++;
          if (rsp_rdata !== e.data) begin
            errors++;
            $display("FAIL sb_rdata: got %h want %h", rsp_rdata, e.data);
          end
        end
      end else begin
        checks++;
        if (rsp_valid !== '0) begin
          errors++;
          $display("FAIL sb_spurious: rsp_valid=%b want 000", rsp_valid);
        end
      end
      checks++;
      if (!$onehot0(req_ready) || (req_ready & ~req_valid) != '0) begin
        errors++;
        $display("FAIL ready_legal: req_ready=%b req_valid=%b",
                 req_ready, req_valid);
      end
      if (req_ready === '0) begin
        checks++;
        if (mem_ctrl.wenable !== 1'b0) begin
          errors++;
          $display("FAIL idle_wen: got %b want 0", mem_ctrl.wenable);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    reset = 1'b1;
    req_valid = '0;
    req_lock = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '1;
    step();
    @(negedge clock);
    checks++;
    if (req_ready !== '0 || mem_ctrl.wenable !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b wen=%b want 000/0",
               req_ready, mem_ctrl.wenable);
    end
    step();
    reset = 1'b0;
    req_valid = '0;
    @(negedge clock);
    checks++;
    if (mem_ctrl !== MEM_IDLE || req_ready !== '0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL reset_idle: ctrl=%h ready=%b rsp=%b want idle/000/000",
               mem_ctrl, req_ready, rsp_valid);
    end
  endtask

  task automatic test_single_read();
    step();
    req_valid = 3'b001;
    req_ctrl[0] = rd(32'h10);
    @(negedge clock);
    checks++;
    if (req_ready !== 3'b001 || mem_ctrl.addr !== 32'h10) begin
      errors++;
      $display("FAIL single_grant: ready=%b addr=%h want 001/10",
               req_ready, mem_ctrl.addr);
    end
    sb.push_back('{idx: 0, rd: 1'b1, data: 32'hDEADBEEF});
    step();
    req_valid = '0;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 3'b001 || rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_rsp: rsp=%b data=%h want 001/deadbeef",
               rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] want;
    pulse_reset();
    for (int i = 0; i < N; i++) req_ctrl[i] = rd(32'h100 + 4 * i);
    for (int k = 0; k < 6; k++) begin
      req_valid = '1;
      @(negedge clock);
      want = N'(1) << (k % 3);
      checks++;
      if (req_ready !== want) begin
        errors++;
        $display("FAIL fair_grant_%0d: got %b want %b", k, req_ready, want);
      end
      sb.push_back('{idx: k % 3, rd: 1'b1, data: init_word('h40 + k % 3)});
      if (k > 0) begin
        want = N'(1) << ((k - 1) % 3);
        checks++;
        if (rsp_valid !== want) begin
          errors++;
          $display("FAIL fair_rsp_%0d: got %b want %b", k, rsp_valid, want);
        end
      end
      step();
    end
    req_valid = '0;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 3'b100) begin
      errors++;
      $display("FAIL fair_rsp_last: got %b want 100", rsp_valid);
    end
  endtask

  task automatic test_write();
    step();
    req_valid = 3'b100;
    req_ctrl[2] = wr(32'hC10, 32'h12345655, write_byte);
    @(negedge clock);
    checks++;
    if (req_ready !== 3'b100 || mem_ctrl.wenable !== 1'b1 ||
        mem_ctrl.addr !== 32'hC10) begin
      errors++;
      $display("FAIL wr_grant: ready=%b wen=%b addr=%h want 100/1/c10",
               req_ready, mem_ctrl.wenable, mem_ctrl.addr);
    end
    sb.push_back('{idx: 2, rd: 1'b0, data: '0});
    step();
    req_valid = 3'b001;
    req_ctrl[0] = rd(32'hC10);
    @(negedge clock);
    checks++;
    if (rsp_valid !== 3'b100 || mem_ctrl.wenable !== 1'b0 ||
        req_ready !== 3'b001) begin
      errors++;
      $display("FAIL wr_ack: rsp=%b wen=%b ready=%b want 100/0/001",
               rsp_valid, mem_ctrl.wenable, req_ready);
    end
    sb.push_back('{idx: 0, rd: 1'b1, data: 32'hAABBCC55});
    step();
    req_valid = '0;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 3'b001 || rsp_rdata !== 32'hAABBCC55) begin
      errors++;
      $display("FAIL wr_readback: rsp=%b data=%h want 001/aabbcc55",
               rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_withdraw();
    pulse_reset();
    req_valid = 3'b011;
    req_ctrl[0] = rd(32'h10);
    req_ctrl[1] = rd(32'h20);
    @(negedge clock);
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL wd_grant: got %b want 001", req_ready);
    end
    sb.push_back('{idx: 0, rd: 1'b1, data: 32'hDEADBEEF});
    step();
    req_valid = '0;
    @(negedge clock);
    checks++;
    if (req_ready !== '0 || mem_ctrl.wenable !== 1'b0 ||
        rsp_valid !== 3'b001) begin
      errors++;
      $display("FAIL wd_idle: ready=%b wen=%b rsp=%b want 000/0/001",
               req_ready, mem_ctrl.wenable, rsp_valid);
    end
    step();
    @(negedge clock);
    checks++;
    if (rsp_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL wd_no_rsp1: got %b want 0", rsp_valid[1]);
    end
  endtask

  task automatic test_reset_mid_op();
    step();
    req_valid = 3'b010;
    for (int i = 0; i < N; i++) req_ctrl[i] = rd(32'h10 + 16 * i);
    @(negedge clock);
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL rmo_grant: got %b want 010", req_ready);
    end
    sb.push_back('{idx: 1, rd: 1'b1, data: init_word(8)});
    step();
    reset = 1'b1;
    req_valid = '1;
    @(negedge clock);
    checks++;
    if (rsp_valid !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL rmo_drop: rsp=%b ready=%b want 000/000",
               rsp_valid, req_ready);
    end
    step();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 3'b001 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL rmo_after: ready=%b rsp=%b want 001/000",
               req_ready, rsp_valid);
    end
    sb.push_back('{idx: 0, rd: 1'b1, data: 32'hDEADBEEF});
    step();
    req_valid = '0;
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] seq [5];
    logic [N-1:0] vin [5];
    logic [N-1:0] lin [5];
    seq = '{3'b010, 3'b000, 3'b010, 3'b100, 3'b001};
    vin = '{3'b111, 3'b101, 3'b111, 3'b101, 3'b101};
    lin = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    pulse_reset();
    req_valid = 3'b001;
    req_ctrl[0] = rd(32'h10);
    @(negedge clock);
    sb.push_back('{idx: 0, rd: 1'b1, data: 32'hDEADBEEF});
    for (int k = 0; k < 5; k++) begin
      step();
      req_valid = vin[k];
      req_lock = lin[k];
      req_ctrl[1] = (k == 2) ? wr(32'h24, 32'hCAFEF00D, write_word)
                             : rd(32'h20);
      @(negedge clock);
      checks++;
      if (req_ready !== seq[k]) begin
        errors++;
        $display("FAIL lock_seq_%0d: got %b want %b", k, req_ready, seq[k]);
      end
      if (seq[k] == 3'b010)
        sb.push_back('{idx: 1, rd: (k != 2), data: init_word(8)});
      else if (seq[k] == 3'b100)
        sb.push_back('{idx: 2, rd: 1'b1, data: init_word(12)});
      else if (seq[k] == 3'b001)
        sb.push_back('{idx: 0, rd: 1'b1, data: 32'hDEADBEEF});
    end
    step();
    req_valid = '0;
    req_lock = '0;
  endtask
`else
  task automatic test_lock_ignored();
    pulse_reset();
    req_valid = 3'b001;
    req_ctrl[0] = rd(32'h10);
    @(negedge clock);
    sb.push_back('{idx: 0, rd: 1'b1, data: 32'hDEADBEEF});
    step();
    req_valid = '1;
    req_lock = 3'b010;
    @(negedge clock);
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL nolock_a: got %b want 010", req_ready);
    end
    sb.push_back('{idx: 1, rd: 1'b1, data: init_word(8)});
    step();
    @(negedge clock);
    checks++;
    if (req_ready !== 3'b100) begin
      errors++;
      $display("FAIL nolock_b: got %b want 100", req_ready);
    end
    sb.push_back('{idx: 2, rd: 1'b1, data: init_word(12)});
    step();
    req_valid = '0;
    req_lock = '0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_lock = '0;
    req_ctrl = '0;
    test_reset();
    test_single_read();
    test_fairness();
    test_write();
    test_withdraw();
    test_reset_mid_op();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`else
    test_lock_ignored();
`endif
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
